rx_block_sync: RTL and testbench
================================

# rx_block_sync

Receive-path 64b/66b block synchronizer. It sits between the RX gearbox and the descrambler/`xgmii_decoder` pair. It watches the 2-bit sync header of every 66-bit block, tells the gearbox to slip one bit while unaligned, and drives the `block_lock` qualifier consumed by the decoder. The lock/unlock behaviour follows IEEE 802.3 Clause 49.2.13.2.2, with a configurable post-slip settle window.

## Interface

**Parameters**
- `HDR_WIDTH`, default 2: sync header width.
- `SH_CNT_MAX`, default 64: headers per test window.
- `SH_INVLD_MAX`, default 16: invalid headers in one window that cause loss of lock.
- `SLIP_WAIT`, default 2: header strobes ignored after a slip while the gearbox re-aligns. Range 1..15.

**Ports**
- `i_clk`, input, 1: sole clock.
- `i_reset`, input, 1: asynchronous, active-high reset.
- `i_rx_hdr`, input, HDR_WIDTH: sync header from the gearbox.
- `i_rx_hdr_valid`, input, 1: `i_rx_hdr` is valid this cycle. Asserted once per 66-bit block, i.e. every other 32-bit word.
- `o_slip`, output, 1: one-cycle pulse; the gearbox shifts its alignment by one bit.
- `o_block_lock`, output, 1: block alignment acquired; drives `i_block_lock` of `xgmii_decoder`.
- `o_hdr_err`, output, 1: one-cycle pulse when a header is invalid (00 or 11), in any state except SLIP_WAIT.

## Operation

- A header is valid when `i_rx_hdr` is 2'b01 or 2'b10. It is invalid when it is 2'b00 or 2'b11.
- Only cycles with `i_rx_hdr_valid`=1 are evaluated. On all other cycles, state and counters hold.

**Counters**
- `sh_cnt` and `sh_invld_cnt` are each $clog2(SH_CNT_MAX+1) bits wide.
- `slip_cnt` is 4 bits wide.
- Counters never wrap; they are cleared explicitly.

**FSM states**
- **RESET_CNT**
  - Clears `sh_cnt` and `sh_invld_cnt`.
  - Moves to TEST_SH on the next cycle, without consuming a header.
- **TEST_SH, unlocked (`o_block_lock`=0)**
  - Each strobe increments `sh_cnt`.
  - On an invalid header: pulse `o_slip`, clear `slip_cnt`, go to SLIP_WAIT.
  - If `sh_cnt` reaches SH_CNT_MAX with every header valid: set `o_block_lock`=1, go to RESET_CNT.
- **TEST_SH, locked (`o_block_lock`=1)**
  - Each strobe increments `sh_cnt`.
  - Each invalid header also increments `sh_invld_cnt`.
  - If `sh_invld_cnt` reaches SH_INVLD_MAX: clear `o_block_lock`, pulse `o_slip`, go to SLIP_WAIT.
  - Otherwise, if `sh_cnt` reaches SH_CNT_MAX: go to RESET_CNT, and lock is held.
  - If both conditions are met on the same strobe, the invalid-count rule wins and lock is lost.
- **SLIP_WAIT**
  - Headers are ignored, and `o_hdr_err` is suppressed.
  - `slip_cnt` increments per strobe.
  - After SLIP_WAIT strobes, go to RESET_CNT.

**Reset**
- `i_reset` forces RESET_CNT from any state.
- Reset clears all counters.
- Reset drives `o_block_lock`=0, `o_slip`=0 and `o_hdr_err`=0 immediately, even mid-window or mid-slip.

## Timing

- All outputs are registered.
- **`o_hdr_err`:** high in cycle N+1 for an invalid header strobed in cycle N.
- **`o_slip`:** high for exactly cycle N+1 after the header strobe in cycle N that triggers it. It is never asserted on two consecutive cycles.
- **Lock rise:** `o_block_lock` rises in the cycle after the SH_CNT_MAX-th consecutive valid strobe.
- **Lock fall:** `o_block_lock` falls in the same cycle that `o_slip` pulses.
- **Minimum relock time:** slip, then SLIP_WAIT strobes, then one RESET_CNT cycle, then SH_CNT_MAX valid strobes.
- **RESET_CNT cycle:** takes exactly one clock. A strobe arriving during it is dropped.
  - This is harmless because strobes arrive at most every second cycle.
  - The bench keeps `i_rx_hdr_valid` at 50% duty or less.

## Test plan

- **Basic lock:** reset, then 64 strobes of hdr=01 on alternate cycles → `o_block_lock`=0 through the 64th strobe, 1 on the following cycle, `o_slip` never asserted.
- **Unlocked error:** after reset, 10 valid headers then hdr=11 → `o_hdr_err` and `o_slip` pulse together one cycle later. The next 2 strobes are ignored (hdr=00 there gives no `o_hdr_err`). Lock then requires 64 further valid strobes.
- **Tolerated errors while locked:** once locked, a 64-header window containing 15 invalid headers → 15 `o_hdr_err` pulses, `o_block_lock` stays 1, no slip. The counters restart for the next window.
- **Loss of lock:** once locked, 16 invalid headers within one window → on the 16th, `o_block_lock` falls and `o_slip` pulses in the same cycle. This holds even when the 16th invalid header is also the 64th header of the window.
- **Strobe gaps:** `i_rx_hdr_valid` low for 20 cycles mid-window, with garbage on `i_rx_hdr` → no counter change, no `o_hdr_err`. The window completes after the remaining strobes.
- **Reset mid-operation:** assert `i_reset` asynchronously while locked, and again mid-SLIP_WAIT → outputs are 0 immediately. After release, lock requires a full 64 valid strobes.

Source files
------------

// File: rtl/rx_block_sync.sv
// 64b/66b receive block synchronizer: watches sync headers, slips the gearbox while
// unaligned and qualifies the downstream decoder with block_lock.
module rx_block_sync #(
    parameter int unsigned HDR_WIDTH    = 2,
    parameter int unsigned SH_CNT_MAX   = 64,
    parameter int unsigned SH_INVLD_MAX = 16,
    parameter int unsigned SLIP_WAIT    = 2
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [HDR_WIDTH-1:0] i_rx_hdr,
    input  logic                 i_rx_hdr_valid,
    output logic                 o_slip,
    output logic                 o_block_lock,
    output logic                 o_hdr_err
);

    localparam int unsigned CW  = $clog2(SH_CNT_MAX + 1);
    localparam int unsigned SCW = 4;

    typedef enum logic [1:0] {
        ST_RESET_CNT = 2'd0,
        ST_TEST_SH   = 2'd1,
        ST_SLIP_WAIT = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_sh_cnt;
    logic [CW-1:0]   r_sh_invld_cnt;
    logic [SCW-1:0]  r_slip_cnt;
    logic [CW-1:0]   w_sh_cnt_nxt;
    logic [CW-1:0]   w_sh_invld_cnt_nxt;
    logic [SCW-1:0]  w_slip_cnt_nxt;
    logic            w_lock_nxt;
    logic            w_slip_nxt;
    logic            w_hdr_err_nxt;

    logic            w_hdr_ok;
    logic            w_hdr_bad;
    logic [CW-1:0]   w_sh_inc;
    logic [CW-1:0]   w_invld_inc;
    logic [SCW-1:0]  w_slip_inc;
    logic            w_sh_done;
    logic            w_invld_hit;
    logic            w_slip_done;

    // Only 01 and 10 are legal sync headers
    assign w_hdr_ok    = (i_rx_hdr == HDR_WIDTH'(1)) || (i_rx_hdr == HDR_WIDTH'(2));
    assign w_hdr_bad   = i_rx_hdr_valid && !w_hdr_ok;
    assign w_sh_inc    = r_sh_cnt + CW'(1);
    assign w_invld_inc = r_sh_invld_cnt + CW'(w_hdr_bad);
    assign w_slip_inc  = r_slip_cnt + SCW'(1);
    assign w_sh_done   = (w_sh_inc == CW'(SH_CNT_MAX));
    assign w_invld_hit = (w_invld_inc == CW'(SH_INVLD_MAX));
    assign w_slip_done = (w_slip_inc == SCW'(SLIP_WAIT));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state        <= ST_RESET_CNT;
            r_sh_cnt       <= '0;
            r_sh_invld_cnt <= '0;
            r_slip_cnt     <= '0;
            o_block_lock   <= 1'b0;
            o_slip         <= 1'b0;
            o_hdr_err      <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_sh_cnt       <= w_sh_cnt_nxt;
            r_sh_invld_cnt <= w_sh_invld_cnt_nxt;
            r_slip_cnt     <= w_slip_cnt_nxt;
            o_block_lock   <= w_lock_nxt;
            o_slip         <= w_slip_nxt;
            o_hdr_err      <= w_hdr_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RESET_CNT: w_state_nxt = ST_TEST_SH;
            ST_TEST_SH: begin
                if (i_rx_hdr_valid) begin
                    if (!o_block_lock) begin
                        if (w_hdr_bad)      w_state_nxt = ST_SLIP_WAIT;
                        else if (w_sh_done) w_state_nxt = ST_RESET_CNT;
                    end else begin
                        // Invalid-count limit takes priority over window end
                        if (w_invld_hit)    w_state_nxt = ST_SLIP_WAIT;
                        else if (w_sh_done) w_state_nxt = ST_RESET_CNT;
                    end
                end
            end
            ST_SLIP_WAIT: begin
                if (i_rx_hdr_valid && w_slip_done) w_state_nxt = ST_RESET_CNT;
            end
            default: w_state_nxt = ST_RESET_CNT;
        endcase
    end

    always_comb begin
        w_sh_cnt_nxt       = r_sh_cnt;
        w_sh_invld_cnt_nxt = r_sh_invld_cnt;
        w_slip_cnt_nxt     = r_slip_cnt;
        w_lock_nxt         = o_block_lock;
        w_slip_nxt         = 1'b0;
        w_hdr_err_nxt      = w_hdr_bad && (r_state != ST_SLIP_WAIT);
        case (r_state)
            ST_RESET_CNT: begin
                w_sh_cnt_nxt       = '0;
                w_sh_invld_cnt_nxt = '0;
            end
            ST_TEST_SH: begin
                if (i_rx_hdr_valid) begin
                    w_sh_cnt_nxt = w_sh_inc;
                    if (!o_block_lock) begin
                        if (w_hdr_bad) begin
                            w_slip_nxt     = 1'b1;
                            w_slip_cnt_nxt = '0;
                        end else if (w_sh_done) begin
                            w_lock_nxt = 1'b1;
                        end
                    end else begin
                        w_sh_invld_cnt_nxt = w_invld_inc;
                        if (w_invld_hit) begin
                            w_lock_nxt     = 1'b0;
                            w_slip_nxt     = 1'b1;
                            w_slip_cnt_nxt = '0;
                        end
                    end
                end
            end
            ST_SLIP_WAIT: begin
                if (i_rx_hdr_valid) w_slip_cnt_nxt = w_slip_inc;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rx_block_sync.sv
// Directed bench for rx_block_sync: stimulus queues per-cycle expected outputs,
// a monitor pops and compares them every cycle.
module tb_rx_block_sync;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic [1:0] i_rx_hdr;
    logic       i_rx_hdr_valid;
    logic       o_slip;
    logic       o_block_lock;
    logic       o_hdr_err;

    rx_block_sync dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_rx_hdr       (i_rx_hdr),
        .i_rx_hdr_valid (i_rx_hdr_valid),
        .o_slip         (o_slip),
        .o_block_lock   (o_block_lock),
        .o_hdr_err      (o_hdr_err)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        int   c;
        logic lock;
        logic slip;
        logic err;
    } exp_t;

    exp_t  q[$];
    int    vectors     = 0;
    int    miscompares = 0;
    int    imm_req     = 0;
    int    imm_ack     = 0;
    bit    done        = 1'b0;
    string tname       = "reset";
    event  ev_imm;

    task automatic push(input int c, input logic l, input logic s, input logic e);
        exp_t x;
        x.c = c; x.lock = l; x.slip = s; x.err = e;
        q.push_back(x);
    endtask

    // One header strobe followed by one idle cycle carrying garbage
    task automatic slot(input logic [1:0] h, input logic la, input logic s, input logic e);
        @(posedge i_clk); #1;
        i_rx_hdr_valid = 1'b1; i_rx_hdr = h;
        push(cyc + 1, la, s, e);
        @(posedge i_clk); #1;
        i_rx_hdr_valid = 1'b0; i_rx_hdr = 2'b11;
        push(cyc + 1, la, 1'b0, 1'b0);
    endtask

    task automatic lock_run(input int n, input logic [1:0] h, input logic pre, input logic last);
        for (int i = 0; i < n; i++) slot(h, (i == n - 1) ? last : pre, 1'b0, 1'b0);
    endtask

    task automatic reset_pulse(input int hold);
        @(posedge i_clk); #3;
        i_reset = 1'b1;
        #1;
        q.delete();
        imm_req++;
        ->ev_imm;
        for (int i = 1; i <= hold; i++) push(cyc + i, 1'b0, 1'b0, 1'b0);
        repeat (hold) @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        push(cyc, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk or ev_imm);
            if (imm_ack != imm_req) begin
                imm_ack = imm_req;
                vectors++;
                if ({o_block_lock, o_slip, o_hdr_err} !== 3'b000) begin
                    miscompares++;
                    $display("FAIL %s async_reset: got lock=%b slip=%b err=%b, want 000",
                             tname, o_block_lock, o_slip, o_hdr_err);
                end
            end else begin
                while (q.size() > 0 && q[0].c <= cyc) begin
                    e = q.pop_front();
                    vectors++;
                    if (e.c != cyc) begin
                        miscompares++;
                        $display("FAIL %s stale_expect: at cyc %0d, want cyc %0d", tname, cyc, e.c);
                    end else if ({o_block_lock, o_slip, o_hdr_err} !== {e.lock, e.slip, e.err}) begin
                        miscompares++;
                        $display("FAIL %s cyc %0d: got lock=%b slip=%b err=%b, want lock=%b slip=%b err=%b",
                                 tname, cyc, o_block_lock, o_slip, o_hdr_err, e.lock, e.slip, e.err);
                    end
                end
                if (done) begin
                    vectors++;
                    if (q.size() != 0) begin
                        miscompares++;
                        $display("FAIL leftover_expect: got %0d pending, want 0", q.size());
                    end
                    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
                    $finish;
                end
            end
        end
    end

    initial begin
        logic inv;
        logic last;
        i_reset = 1'b1; i_rx_hdr_valid = 1'b0; i_rx_hdr = 2'b00;
        @(posedge i_clk); #1;
        push(cyc, 1'b0, 1'b0, 1'b0);
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        push(cyc, 1'b0, 1'b0, 1'b0);

        tname = "basic_lock";
        lock_run(64, 2'b01, 1'b0, 1'b1);

        tname = "unlocked_err";
        reset_pulse(2);
        lock_run(10, 2'b01, 1'b0, 1'b0);
        slot(2'b11, 1'b0, 1'b1, 1'b1);
        slot(2'b00, 1'b0, 1'b0, 1'b0);
        slot(2'b00, 1'b0, 1'b0, 1'b0);
        lock_run(64, 2'b10, 1'b0, 1'b1);

        tname = "tolerated_errs";
        for (int i = 0; i < 64; i++) begin
            inv = ((i % 4) == 0) && (i < 60);
            slot(inv ? 2'b11 : 2'b01, 1'b1, 1'b0, inv);
        end

        tname = "loss_at_window_end";
        for (int i = 0; i < 64; i++) begin
            inv  = (i >= 48);
            last = (i == 63);
            slot(inv ? 2'b00 : 2'b10, !last, last, inv);
        end
        slot(2'b11, 1'b0, 1'b0, 1'b0);
        slot(2'b11, 1'b0, 1'b0, 1'b0);
        lock_run(64, 2'b01, 1'b0, 1'b1);

        tname = "loss_mid_window";
        lock_run(5, 2'b01, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) slot(2'b11, i != 15, i == 15, 1'b1);
        slot(2'b11, 1'b0, 1'b0, 1'b0);
        slot(2'b00, 1'b0, 1'b0, 1'b0);

        tname = "strobe_gap";
        lock_run(30, 2'b01, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(posedge i_clk); #1;
            i_rx_hdr_valid = 1'b0;
            i_rx_hdr = 2'($urandom_range(0, 3));
            push(cyc + 1, 1'b0, 1'b0, 1'b0);
        end
        lock_run(34, 2'b01, 1'b0, 1'b1);

        tname = "reset_locked";
        lock_run(10, 2'b10, 1'b1, 1'b1);
        reset_pulse(3);
        lock_run(64, 2'b01, 1'b0, 1'b1);

        tname = "reset_slip_wait";
        reset_pulse(2);
        lock_run(3, 2'b01, 1'b0, 1'b0);
        slot(2'b11, 1'b0, 1'b1, 1'b1);
        slot(2'b00, 1'b0, 1'b0, 1'b0);
        reset_pulse(2);
        lock_run(64, 2'b10, 1'b0, 1'b1);

        repeat (3) @(posedge i_clk);
        #1;
        done = 1'b1;
    end

endmodule
